snoopy_bus_master: RTL and testbench

//  Bus-side master of a snoopy cache. Takes a miss/upgrade request from the processor-side

---
 rtl/snoopy_bus_master.sv | 135 +++++++++++++
 tb/tb_snoopy_bus_master.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/snoopy_bus_master.sv
// Bus-side master of a snoopy cache: arbitrates for the shared bus,
// broadcasts the command/address and streams read blocks into the cache.
module snoopy_bus_master #(
    parameter int OFFSET_WIDTH = 2,
    parameter int INDEX_WIDTH  = 6,
    parameter int TAG_WIDTH    = 8,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic                                      reqValid,
    input  logic [1:0]                                reqCommand,
    input  logic [TAG_WIDTH+INDEX_WIDTH-1:0]          reqBlockAddress,
    output logic                                      done,
    output logic                                      arbiterRequest,
    input  logic                                      arbiterGrant,
    output logic [1:0]                                busCommand,
    output logic [TAG_WIDTH+INDEX_WIDTH+OFFSET_WIDTH-1:0] busAddress,
    output logic                                      busReadEnabled,
    input  logic                                      busFunctionComplete,
    input  logic [DATA_WIDTH-1:0]                     busDataIn,
    output logic                                      fillWrite,
    output logic [OFFSET_WIDTH-1:0]                   fillOffset,
    output logic [DATA_WIDTH-1:0]                     fillData
);

    localparam int BW = TAG_WIDTH + INDEX_WIDTH;

    localparam logic [1:0] CMD_NONE       = 2'd0;
    localparam logic [1:0] CMD_INVALIDATE = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        ARBITRATE,
        INVALIDATE,
        READ_WORD,
        WAIT_ACK,
        FINISH
    } state_t;

    state_t                  state;
    logic [1:0]              cmdLatch;
    logic [BW-1:0]           blockLatch;
    logic [OFFSET_WIDTH-1:0] offset;
    logic [OFFSET_WIDTH-1:0] nextOffset;
    logic                    owning;

    assign nextOffset = offset + OFFSET_WIDTH'(1);

    assign owning = (state == INVALIDATE) || (state == READ_WORD) ||
                    (state == WAIT_ACK)   || (state == FINISH);

    // Request FSM; every output is a register updated here
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cmdLatch       <= CMD_NONE;
            blockLatch     <= '0;
            offset         <= '0;
            done           <= 1'b0;
            arbiterRequest <= 1'b0;
            busCommand     <= CMD_NONE;
            busAddress     <= '0;
            busReadEnabled <= 1'b0;
            fillWrite      <= 1'b0;
            fillOffset     <= '0;
            fillData       <= '0;
        end else begin
            fillWrite <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (reqValid && reqCommand != CMD_NONE) begin
                        cmdLatch       <= reqCommand;
                        blockLatch     <= reqBlockAddress;
                        arbiterRequest <= 1'b1;
                        state          <= ARBITRATE;
                    end
                end
                ARBITRATE: begin
                    if (arbiterGrant) begin
                        busCommand <= cmdLatch;
                        busAddress <= {blockLatch, {OFFSET_WIDTH{1'b0}}};
                        offset     <= '0;
                        if (cmdLatch == CMD_INVALIDATE) begin
                            state <= INVALIDATE;
                        end else begin
                            busReadEnabled <= 1'b1;
                            state          <= READ_WORD;
                        end
                    end
                end
                INVALIDATE: begin
                    // peers act on the invalidate during its single bus cycle
                    busCommand <= CMD_NONE;
                    state      <= FINISH;
                end
                READ_WORD: begin
                    if (busFunctionComplete) begin
                        fillData       <= busDataIn;
                        fillOffset     <= offset;
                        fillWrite      <= 1'b1;
                        busReadEnabled <= 1'b0;
                        offset         <= nextOffset;
                        busAddress     <= {blockLatch, nextOffset};
                        state          <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (offset != '0) begin
                        busReadEnabled <= 1'b1;
                        state          <= READ_WORD;
                    end else begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    busCommand     <= CMD_NONE;
                    arbiterRequest <= 1'b0;
                    done           <= 1'b1;
                    state          <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Losing the grant while driving the bus is unrecoverable
    a_grant_held : assert property (
        @(posedge clock) disable iff (reset) owning |-> arbiterGrant
    );

endmodule

// File: tb/tb_snoopy_bus_master.sv
// Self-checking bench for snoopy_bus_master: table vectors, hand-written
// corner sequences and randomized transactions against a transaction model.
module tb_snoopy_bus_master;

    localparam int OW = 2;
    localparam int IW = 6;
    localparam int TW = 8;
    localparam int DW = 32;
    localparam int BW = TW + IW;
    localparam int AW = BW + OW;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          reqValid = 1'b0;
    logic [1:0]    reqCommand = 2'd0;
    logic [BW-1:0] reqBlockAddress = '0;
    logic          done;
    logic          arbiterRequest;
    logic          arbiterGrant;
    logic [1:0]    busCommand;
    logic [AW-1:0] busAddress;
    logic          busReadEnabled;
    logic          busFunctionComplete;
    logic [DW-1:0] busDataIn;
    logic          fillWrite;
    logic [OW-1:0] fillOffset;
    logic [DW-1:0] fillData;

    int nvec = 0;
    int nmis = 0;
    int gdelay = 0;
    int sdelay = 1;
    int gcnt;
    int scnt;

    snoopy_bus_master #(
        .OFFSET_WIDTH(OW), .INDEX_WIDTH(IW),
        .TAG_WIDTH(TW), .DATA_WIDTH(DW)
    ) dut (
        .clock(clock), .reset(reset),
        .reqValid(reqValid), .reqCommand(reqCommand),
        .reqBlockAddress(reqBlockAddress), .done(done),
        .arbiterRequest(arbiterRequest), .arbiterGrant(arbiterGrant),
        .busCommand(busCommand), .busAddress(busAddress),
        .busReadEnabled(busReadEnabled),
        .busFunctionComplete(busFunctionComplete),
        .busDataIn(busDataIn), .fillWrite(fillWrite),
        .fillOffset(fillOffset), .fillData(fillData)
    );

    always #5 clock = ~clock;

    // memory / peer contents for a block word
    function automatic logic [DW-1:0] memword(input logic [BW-1:0] a,
                                              input logic [OW-1:0] o);
        if (a == {8'h5A, 6'h13}) return 32'hA0 + 32'(o);
        return {a, o, 16'hC0DE};
    endfunction

    // arbiter: grants gdelay cycles after the request is seen, holds it
    always @(posedge clock or posedge reset) begin
        if (reset) gcnt <= 0;
        else if (arbiterRequest) gcnt <= gcnt + 1;
        else gcnt <= 0;
    end
    assign arbiterGrant = arbiterRequest && (gcnt >= gdelay);

    // slave: complete appears sdelay cycles after the strobe is seen
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            scnt <= 0;
            busFunctionComplete <= 1'b0;
        end else if (busReadEnabled) begin
            scnt <= scnt + 1;
            busFunctionComplete <= (scnt + 1 >= sdelay);
        end else begin
            scnt <= 0;
            busFunctionComplete <= 1'b0;
        end
    end
    assign busDataIn = memword(busAddress[AW-1:OW], busAddress[OW-1:0]);

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // cycle (counting the accept cycle as 0) in which done is seen
    function automatic int model_latency(input logic [1:0] cmd,
                                         input int g, input int d);
        if (cmd == 2'd3) return 4 + g;
        return 3 + g + (1 << OW) * (d + 2);
    endfunction

    task automatic run_txn(input logic [1:0] cmd, input logic [BW-1:0] blk,
                           input int g, input int d, input bit noise,
                           input int expLat, input int expFills);
        logic [OW-1:0] fo[$];
        logic [DW-1:0] fd[$];
        int doneCyc = -1;
        int cmdc = 0, renc = 0, overlap = 0, badaddr = 0;
        int seqLen = 0, expLen, arbAtDone = 1;
        logic [31:0] seq = 0, expSeq = 0;
        logic [OW-1:0] lastOff = '0;
        logic [OW-1:0] o;
        bit isRead = (cmd != 2'd3);
        int words = 1 << OW;
        gdelay = g;
        sdelay = d;
        reqValid = 1'b1;
        reqCommand = cmd;
        reqBlockAddress = blk;
        @(posedge clock);
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clock);
            if (fillWrite) begin
                fo.push_back(fillOffset);
                fd.push_back(fillData);
            end
            if (fillWrite && done) overlap++;
            if (busCommand == cmd) cmdc++;
            if (busReadEnabled) renc++;
            if (busCommand != 2'd0) begin
                if (busAddress[AW-1:OW] != blk) badaddr++;
                o = busAddress[OW-1:0];
                if (seqLen == 0 || o != lastOff) begin
                    seq = seq * 4 + 32'(o);
                    seqLen++;
                    lastOff = o;
                end
            end
            if (done) begin
                doneCyc = cyc;
                arbAtDone = int'(arbiterRequest);
                break;
            end
            if (noise) begin
                reqValid = 1'($urandom % 2);
                reqCommand = 2'($urandom % 4);
                reqBlockAddress = BW'($urandom);
            end else begin
                reqValid = 1'b0;
            end
        end
        reqValid = 1'b0;
        chk("done_latency", doneCyc, expLat);
        chk("fill_count", fo.size(), expFills);
        for (int i = 0; i < fo.size(); i++) begin
            chk("fill_offset", 32'(fo[i]), i % words);
            chk("fill_data", fd[i], memword(blk, OW'(i)));
        end
        chk("cmd_cycles", cmdc,
            isRead ? words * (d + 2) + 1 : 1);
        chk("ren_cycles", renc, isRead ? words * (d + 1) : 0);
        chk("bus_block_addr", badaddr, 0);
        expLen = isRead ? words + 1 : 1;
        for (int i = 0; i < expLen; i++)
            expSeq = expSeq * 4 + 32'(i % words);
        chk("offset_seq_len", seqLen, expLen);
        chk("offset_seq", seq, expSeq);
        chk("fill_done_overlap", overlap, 0);
        chk("arbreq_at_done", arbAtDone, 0);
        @(negedge clock);
        chk("done_single_pulse", 32'(done), 0);
        chk("cmd_released", 32'(busCommand), 0);
    endtask

    typedef struct {
        logic [1:0]    cmd;
        logic [BW-1:0] blk;
        int            g;
        int            d;
        int            lat;
        int            fills;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int hits;
        int arbSeen;
        tbl[0] = '{2'd1, {8'h5A, 6'h13}, 0, 1, 15, 4};
        tbl[1] = '{2'd3, 14'h2ABC,       3, 1, 7,  0};
        tbl[2] = '{2'd2, 14'h0F0F,       0, 5, 31, 4};
        tbl[3] = '{2'd1, 14'h3FFF,       2, 2, 21, 4};
        tbl[4] = '{2'd3, 14'h0001,       0, 1, 4,  0};

        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk("reset_done", 32'(done), 0);
        chk("reset_arbreq", 32'(arbiterRequest), 0);
        chk("reset_cmd", 32'(busCommand), 0);
        chk("reset_ren", 32'(busReadEnabled), 0);
        chk("reset_fill", 32'(fillWrite), 0);
        reset = 1'b0;
        @(negedge clock);

        // NONE in IDLE is ignored
        arbSeen = 0;
        reqValid = 1'b1;
        reqCommand = 2'd0;
        reqBlockAddress = 14'h1234;
        repeat (5) begin
            @(negedge clock);
            if (arbiterRequest) arbSeen++;
        end
        reqValid = 1'b0;
        @(negedge clock);
        if (arbiterRequest) arbSeen++;
        chk("none_ignored", arbSeen, 0);

        for (int i = 0; i < 5; i++)
            run_txn(tbl[i].cmd, tbl[i].blk, tbl[i].g, tbl[i].d,
                    1'b0, tbl[i].lat, tbl[i].fills);

        // reset while reading word 2
        gdelay = 0;
        sdelay = 1;
        reqValid = 1'b1;
        reqCommand = 2'd1;
        reqBlockAddress = 14'h1111;
        @(negedge clock);
        reqValid = 1'b0;
        hits = 0;
        for (int c = 0; c < 100; c++) begin
            if (busReadEnabled && busAddress[OW-1:0] == 2'd2) begin
                hits = 1;
                break;
            end
            @(negedge clock);
        end
        chk("reached_offset2", hits, 1);
        reset = 1'b1;
        #1;
        chk("midreset_done", 32'(done), 0);
        chk("midreset_arbreq", 32'(arbiterRequest), 0);
        chk("midreset_cmd", 32'(busCommand), 0);
        chk("midreset_addr", 32'(busAddress), 0);
        chk("midreset_ren", 32'(busReadEnabled), 0);
        chk("midreset_fill", 32'(fillWrite), 0);
        chk("midreset_foff", 32'(fillOffset), 0);
        chk("midreset_fdata", fillData, 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        run_txn(2'd1, 14'h1111, 0, 1, 1'b0, 15, 4);

        // randomized back-to-back requests with noise on reqValid
        for (int i = 0; i < 12; i++) begin
            logic [1:0] c;
            int g, d;
            c = 2'(1 + $urandom % 3);
            g = $urandom % 4;
            d = 1 + $urandom % 4;
            run_txn(c, BW'($urandom), g, d, 1'b1,
                    model_latency(c, g, d), (c == 2'd3) ? 0 : 4);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
